// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: FSM encoding and
// the default operand width.
package div_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/div_repsub_if.sv
// Request/result bundle for div_repsub: the requester drives the operands and
// start; the divider returns quotient, remainder and status.
interface div_repsub_if
   import div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             done;
   logic             busy;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, done, busy, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, done, busy, div_by_zero
   );

endinterface

// File: rtl/div_ctrlpath.sv
// Control FSM for the divider: accepts a start in IDLE/DONE, then steps one
// subtraction per cycle in CHECK until the divisor no longer fits.
module div_ctrlpath
   import div_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic b_zero,
   input  logic a_lt_b,
   output logic ldAB,
   output logic clrQ,
   output logic sub_en,
   output logic fin
);

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ldAB    = 1'b0;
      clrQ    = 1'b0;
      sub_en  = 1'b0;
      fin     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               ldAB    = 1'b1;
               clrQ    = 1'b1;
               state_d = CHECK;
            end
         end
         CHECK: begin
            // A zero divisor would never satisfy A<B, so it terminates here too.
            if (b_zero || a_lt_b) begin
               fin     = 1'b1;
               state_d = DONE;
            end else begin
               sub_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction: datapath registers, comparator and
// subtractor, sequenced by div_ctrlpath.
module div_repsub
   import div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input logic         clk,
   input logic         rst,
   div_repsub_if.slave bus
);

   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d;
   logic             done_q, done_d, busy_q, busy_d, dbz_q, dbz_d;
   logic             ld_ab, clr_q, sub_en, fin, b_zero, a_lt_b;

   assign b_zero = (b_q == '0);
   assign a_lt_b = (a_q < b_q);

   div_ctrlpath u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .start  (bus.start),
      .b_zero (b_zero),
      .a_lt_b (a_lt_b),
      .ldAB   (ld_ab),
      .clrQ   (clr_q),
      .sub_en (sub_en),
      .fin    (fin)
   );

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      q_d    = q_q;
      r_d    = r_q;
      done_d = done_q;
      busy_d = busy_q;
      dbz_d  = dbz_q;
      if (ld_ab) begin
         a_d    = bus.dividend;
         b_d    = bus.divisor;
         done_d = 1'b0;
         dbz_d  = 1'b0;
         busy_d = 1'b1;
      end
      if (clr_q) q_d = '0;
      if (sub_en) begin
         a_d = a_q - b_q;
         q_d = q_q + WIDTH'(1);
      end
      if (fin) begin
         r_d    = a_q;
         done_d = 1'b1;
         busy_d = 1'b0;
         if (b_zero) begin
            dbz_d = 1'b1;
            q_d   = '1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         q_q    <= '0;
         r_q    <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         q_q    <= q_d;
         r_q    <= r_d;
         done_q <= done_d;
         busy_q <= busy_d;
         dbz_q  <= dbz_d;
      end
   end

   // Q only moves in CHECK, so it doubles as the held quotient in DONE.
   assign bus.quotient    = q_q;
   assign bus.remainder   = r_q;
   assign bus.done        = done_q;
   assign bus.busy        = busy_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub (WIDTH=8) against an arithmetic reference.
module tb_div_repsub;
   import div_pkg::*;

   localparam int W     = 8;
   localparam int LIMIT = 400;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   div_repsub_if #(.WIDTH(W)) bus ();

   div_repsub #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference: plain integer division; a zero divisor yields all-ones and A.
   task automatic model(input int a, input int b, output int q, output int r,
                        output logic dbz, output int lat);
      if (b == 0) begin
         q = 255; r = a; dbz = 1'b1; lat = 1;
      end else begin
         q = a / b; r = a % b; dbz = 1'b0; lat = a / b + 1;
      end
   endtask

   // Pulses start for one edge, scrambles the operand inputs, waits for done.
   task automatic run_div(input int a, input int b, output int lat,
                          output int bcnt, output logic d0);
      bus.dividend = W'(a);
      bus.divisor  = W'(b);
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
      d0   = bus.done;
      bcnt = bus.busy ? 1 : 0;
      lat  = 0;
      while (!bus.done && lat < LIMIT) begin
         @(posedge clk); #1;
         lat++;
         if (bus.busy) bcnt++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd3;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_by_zero} !== 19'd0) begin
         errors++;
         $display("FAIL reset_outputs: got q=%0d r=%0d done=%b busy=%b dbz=%b, want all 0",
                  bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_by_zero);
      end
      rst = 1'b0; bus.start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_basic;
      int lat, bcnt; logic d0;
      run_div(100, 7, lat, bcnt, d0);
      checks++;
      if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2 || bus.div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL basic_100_7: got q=%0d r=%0d dbz=%b, want 14 2 0",
                  bus.quotient, bus.remainder, bus.div_by_zero);
      end
      checks++;
      if (lat != 15 || bcnt != 15) begin
         errors++;
         $display("FAIL basic_timing: got lat=%0d busy=%0d, want 15 15", lat, bcnt);
      end
   endtask

   task automatic test_zero_quotient;
      int lat, bcnt; logic d0;
      run_div(5, 9, lat, bcnt, d0);
      checks++;
      if (bus.quotient !== 8'd0 || bus.remainder !== 8'd5 || lat != 1) begin
         errors++;
         $display("FAIL small_5_9: got q=%0d r=%0d lat=%0d, want 0 5 1",
                  bus.quotient, bus.remainder, lat);
      end
      run_div(0, 3, lat, bcnt, d0);
      checks++;
      if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0 || lat != 1) begin
         errors++;
         $display("FAIL zero_0_3: got q=%0d r=%0d lat=%0d, want 0 0 1",
                  bus.quotient, bus.remainder, lat);
      end
   endtask

   task automatic test_div_zero;
      int lat, bcnt; logic d0;
      run_div(13, 0, lat, bcnt, d0);
      checks++;
      if (bus.div_by_zero !== 1'b1 || bus.quotient !== 8'd255 || bus.remainder !== 8'd13) begin
         errors++;
         $display("FAIL divzero_13_0: got dbz=%b q=%0d r=%0d, want 1 255 13",
                  bus.div_by_zero, bus.quotient, bus.remainder);
      end
      checks++;
      if (lat != 1 || bcnt != 1) begin
         errors++;
         $display("FAIL divzero_timing: got lat=%0d busy=%0d, want 1 1", lat, bcnt);
      end
      // Result must stay put while idling in DONE.
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b1 || bus.quotient !== 8'd255 || bus.div_by_zero !== 1'b1) begin
         errors++;
         $display("FAIL divzero_hold: got done=%b q=%0d dbz=%b, want 1 255 1",
                  bus.done, bus.quotient, bus.div_by_zero);
      end
   endtask

   task automatic test_max;
      int lat, bcnt; logic d0;
      run_div(255, 1, lat, bcnt, d0);
      checks++;
      if (bus.quotient !== 8'd255 || bus.remainder !== 8'd0 || lat != 256) begin
         errors++;
         $display("FAIL max_255_1: got q=%0d r=%0d lat=%0d, want 255 0 256",
                  bus.quotient, bus.remainder, lat);
      end
   endtask

   task automatic test_ignore_start;
      int lat;
      bus.dividend = 8'd100; bus.divisor = 8'd7; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < LIMIT) begin
         if (lat == 4) begin
            bus.dividend = 8'd9; bus.divisor = 8'd3; bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      checks++;
      if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2 || lat != 15) begin
         errors++;
         $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d, want 14 2 15",
                  bus.quotient, bus.remainder, lat);
      end
   endtask

   task automatic test_reset_mid;
      int lat, bcnt; logic d0;
      bus.dividend = 8'd100; bus.divisor = 8'd7; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1; bus.start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.start = 1'b0;
      checks++;
      if ({bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_by_zero} !== 19'd0) begin
         errors++;
         $display("FAIL reset_mid: got q=%0d r=%0d done=%b busy=%b dbz=%b, want all 0",
                  bus.quotient, bus.remainder, bus.done, bus.busy, bus.div_by_zero);
      end
      run_div(20, 4, lat, bcnt, d0);
      checks++;
      if (bus.quotient !== 8'd5 || bus.remainder !== 8'd0 || lat != 6) begin
         errors++;
         $display("FAIL after_reset_20_4: got q=%0d r=%0d lat=%0d, want 5 0 6",
                  bus.quotient, bus.remainder, lat);
      end
   endtask

   task automatic test_back_to_back;
      int lat, bcnt; logic d0;
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_precond: got done=%b, want 1", bus.done);
      end
      run_div(50, 5, lat, bcnt, d0);
      checks++;
      if (d0 !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done_drop: got done=%b after start edge, want 0", d0);
      end
      checks++;
      if (bus.quotient !== 8'd10 || bus.remainder !== 8'd0 || lat != 11) begin
         errors++;
         $display("FAIL b2b_50_5: got q=%0d r=%0d lat=%0d, want 10 0 11",
                  bus.quotient, bus.remainder, lat);
      end
   endtask

   task automatic test_random;
      int a, b, lat, bcnt, eq, er, elat; logic d0, edbz;
      for (int i = 0; i < 24; i++) begin
         a = $urandom_range(0, 255);
         case ($urandom_range(0, 3))
            0:       b = 0;
            1:       b = $urandom_range(1, 15);
            default: b = $urandom_range(1, 255);
         endcase
         model(a, b, eq, er, edbz, elat);
         run_div(a, b, lat, bcnt, d0);
         checks++;
         if (int'(bus.quotient) != eq || int'(bus.remainder) != er ||
             bus.div_by_zero !== edbz || lat != elat || bcnt != elat) begin
            errors++;
            $display("FAIL random_%0d_%0d: got q=%0d r=%0d dbz=%b lat=%0d busy=%0d, want %0d %0d %b %0d %0d",
                     a, b, bus.quotient, bus.remainder, bus.div_by_zero, lat, bcnt,
                     eq, er, edbz, elat, elat);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
      test_reset();
      test_basic();
      test_zero_quotient();
      test_div_zero();
      test_max();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_repsub.md
DIV_REPSUB -- requirements
Module: div_repsub

Interface
REQ-001 Parameter WIDTH, default 8: operand, quotient and remainder width in bits.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use one clock.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 dividend  input  WIDTH  unsigned dividend; captured on an accepted start.
REQ-006 divisor  input  WIDTH  unsigned divisor; captured on an accepted start.
REQ-007 quotient  output  WIDTH  result quotient; valid while done=1.
REQ-008 remainder  output  WIDTH  result remainder; valid while done=1.
REQ-009 done  output  1  result valid; held until the next accepted start or rst.
REQ-010 busy  output  1  high while a division is in progress.
REQ-011 div_by_zero  output  1  the captured divisor was 0; valid while done=1.

Function
REQ-012 The block SHALL divide by repeated subtraction, the inverse of the team's repeated-addition multiplier, with an identical start/done handshake.
REQ-013 FSM states: IDLE, CHECK, DONE; reset state IDLE.
REQ-014 IDLE, start=1: capture A<=dividend, B<=divisor, Q<=0, clear done and div_by_zero, go to CHECK.
REQ-015 CHECK, B==0: set div_by_zero=1, Q<=all-ones, R<=A, go to DONE.
REQ-016 CHECK, A>=B and B!=0: A<=A-B, Q<=Q+1, stay in CHECK; exactly one subtraction per cycle.
REQ-017 CHECK, A<B: R<=A, go to DONE.
REQ-018 DONE: done=1, quotient, remainder and div_by_zero held stable; start=1 behaves as in IDLE and done SHALL drop on the next cycle.
REQ-019 Latency: with start accepted at edge k and quotient q, done SHALL rise after edge k+q+1; division by zero completes after edge k+1.
REQ-020 busy SHALL be 1 exactly while in CHECK; start while busy SHALL be ignored and operands SHALL NOT be re-sampled.
REQ-021 Comparison and subtraction SHALL be unsigned and WIDTH bits wide; A never underflows; Q never exceeds the dividend, so Q cannot wrap.
REQ-022 Input changes after capture SHALL NOT affect the result in progress.
REQ-023 Outputs SHALL be registered; no combinational path from the inputs to the outputs.

Reset
REQ-024 On rst=1 at a clock edge, from any state including mid-division, the FSM SHALL go to IDLE.
REQ-025 On that edge, quotient, remainder, done, busy and div_by_zero SHALL go to 0, and internal A, B, Q SHALL be cleared.
REQ-026 rst SHALL take priority over start in the same cycle.

Structure
REQ-027 Package div_pkg SHALL hold the FSM state encoding (2-bit typedef) and the default WIDTH constant.
REQ-028 The FSM SHALL be the sub-module div_ctrlpath, with inputs start, b_zero and a_lt_b and outputs ldAB, clrQ, sub_en and fin; the datapath registers, comparator and subtractor SHALL reside in div_repsub.

Verification (WIDTH=8)
REQ-029 Drive 100/7 with one start pulse -> quotient=14, remainder=2, div_by_zero=0, done rises 15 cycles after the start edge, busy high for 15 cycles.
REQ-030 Drive 5/9 and 0/3 -> 0 rem 5 and 0 rem 0, each with done 1 cycle after the start edge.
REQ-031 Drive 13/0 -> div_by_zero=1, quotient=255, remainder=13, done 1 cycle after the start edge.
REQ-032 Drive 255/1 -> quotient=255, remainder=0, done 256 cycles after the start edge, with no quotient wrap.
REQ-033 During 100/7, pulse start with 9/3 at cycle 4 -> ignored, result 14 rem 2; then assert rst at cycle 5 of a new 100/7 -> all outputs 0 next cycle; then drive 20/4 -> 5 rem 0 in 6 cycles.
REQ-034 In DONE, apply back-to-back start with 50/5 -> done drops for one cycle, then 10 rem 0 after 11 cycles.
